// File: rtl/lifo_pkg.sv
// Shared types for the lifo drain engine: FSM encoding and skid depth.
package lifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/lifo_reader_skid.sv
// Two-entry FIFO that absorbs words already popped from the stack while the consumer stalls.
module lifo_reader_skid
  import lifo_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [SKID_DEPTH];
  logic             rd_ptr;
  logic             wr_ptr;

  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/lifo_reader.sv
// Drains the lifo stack onto a valid/ready stream, hiding the one-cycle read latency in a skid buffer.
module lifo_reader
  import lifo_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 3
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [AWIDTH:0]   words_o,
  output logic              lifo_rdreq_o,
  input  logic [DWIDTH-1:0] lifo_q_i,
  input  logic              lifo_empty_i,
  input  logic [AWIDTH:0]   lifo_usedw_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_o
);

  state_t          state;
  logic            inflight;
  logic            inflight_last;
  logic [1:0]      cnt;
  logic [DWIDTH:0] head;
  logic            pop;
  logic [2:0]      occ_if_read;
  logic            drain_end;
  logic [AWIDTH:0] hs_cnt;

  assign pop     = valid_o & ready_i;
  assign valid_o = (cnt != 2'd0);
  assign data_o  = head[DWIDTH-1:0];
  assign last_o  = valid_o & head[DWIDTH];

  // Skid occupancy after the next edge if a read were issued now; must stay within 2.
  assign occ_if_read  = {1'b0, cnt} - {2'b0, pop} + {2'b0, inflight} + 3'd1;
  assign lifo_rdreq_o = (state == DRAIN) && !lifo_empty_i && (occ_if_read <= 3'd2);

  // Finish on the edge that retires the final word so done follows its handshake directly.
  assign drain_end = lifo_empty_i && !inflight && (cnt == {1'b0, pop});

  lifo_reader_skid #(
    .WIDTH(DWIDTH + 1)
  ) u_skid (
    .clk_i (clk_i),
    .srst_i(srst_i),
    .push  (inflight),
    .wdata ({inflight_last, lifo_q_i}),
    .pop   (pop),
    .count (cnt),
    .head  (head)
  );

  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      state         <= IDLE;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      hs_cnt        <= '0;
      words_o       <= '0;
    end else begin
      inflight <= lifo_rdreq_o;
      if (lifo_rdreq_o) begin
        inflight_last <= (lifo_usedw_i == (AWIDTH + 1)'(1));
      end
      if (pop) begin
        hs_cnt <= hs_cnt + (AWIDTH + 1)'(1);
      end
      case (state)
        IDLE: begin
          if (start_i) begin
            state  <= DRAIN;
            busy_o <= 1'b1;
            hs_cnt <= '0;
          end
        end
        DRAIN: begin
          if (drain_end) begin
            state   <= DONE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            words_o <= hs_cnt + (AWIDTH + 1)'(pop);
          end
        end
        DONE: begin
          state  <= IDLE;
          done_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lifo_reader.sv
// Bench for lifo_reader: behavioural stack model, table-driven drains, random drains and a mid-drain reset.
module tb_lifo_reader;
  import lifo_pkg::*;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int UW = AW + 1;

  logic          clk = 1'b0;
  logic          srst = 1'b0;
  logic          start = 1'b0;
  logic          ready = 1'b0;
  logic          busy, done, rdreq, empty, valid, last;
  logic [AW:0]   words;
  logic [AW:0]   usedw = '0;
  logic [DW-1:0] q = '0;
  logic [DW-1:0] data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lifo_reader #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk_i       (clk),
    .srst_i      (srst),
    .start_i     (start),
    .busy_o      (busy),
    .done_o      (done),
    .words_o     (words),
    .lifo_rdreq_o(rdreq),
    .lifo_q_i    (q),
    .lifo_empty_i(empty),
    .lifo_usedw_i(usedw),
    .data_o      (data),
    .valid_o     (valid),
    .ready_i     (ready),
    .last_o      (last)
  );

  // Stack model: one-cycle read latency, usedw/empty reflect a pop in the following cycle.
  logic [DW-1:0] stk[$];
  logic          wr = 1'b0;
  logic [DW-1:0] wd = '0;

  always @(posedge clk) begin
    if (wr) stk.push_back(wd);
    else if (rdreq && stk.size() > 0) q <= stk.pop_back();
    usedw <= UW'(stk.size());
  end
  assign empty = (usedw == '0);

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic rnd_ready(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  task automatic fill(input int n, input logic [7:0][DW-1:0] d);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 wr = 1'b1; wd = d[i];
    end
    @(posedge clk); #1 wr = 1'b0;
  endtask

  task automatic drain(input int pct, input bit mid, input int exp_words, input string tag);
    logic [DW:0]   exp_q[$];
    logic [DW:0]   got[$];
    int            n, first_v, last_hs, done_k;
    bit            pv, pr;
    logic [DW-1:0] pd;
    n = stk.size();
    for (int i = n - 1; i >= 0; i--) exp_q.push_back({(i == 0), stk[i]});
    @(posedge clk); #1 start = 1'b1; ready = rnd_ready(pct);
    @(posedge clk); #1 start = 1'b0; ready = rnd_ready(pct);
    first_v = -1; last_hs = -1; done_k = -1; pv = 1'b0; pr = 1'b0; pd = '0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      if (cyc == 1) chk({tag, ".busy_t1"}, busy, 1);
      if (cyc == 1 && n > 0) chk({tag, ".rdreq_t1"}, rdreq, 1);
      chk({tag, ".rdreq_while_empty"}, rdreq & empty, 0);
      chk({tag, ".skid_le2"}, (dut.cnt <= 2'd2), 1);
      if (pv && !pr) begin
        chk({tag, ".stall_valid"}, valid, 1);
        chk({tag, ".stall_data"}, data, pd);
      end
      if (valid && first_v < 0) first_v = cyc;
      if (done) begin
        done_k = cyc;
        break;
      end
      if (valid && ready) begin
        got.push_back({last, data});
        last_hs = cyc;
      end
      pv = valid; pr = ready; pd = data;
      @(posedge clk); #1 ready = rnd_ready(pct); start = mid && (cyc == 4);
    end
    start = 1'b0;
    chk({tag, ".done_seen"}, (done_k > 0), 1);
    chk({tag, ".count"}, got.size(), exp_words);
    chk({tag, ".words_o"}, words, exp_words);
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("%s.word%0d", tag, i), got[i], exp_q[i]);
    if (n == 0) begin
      chk({tag, ".done_at_t2"}, done_k, 2);
      chk({tag, ".never_valid"}, first_v, -1);
    end else begin
      chk({tag, ".first_valid_t3"}, first_v, 3);
      chk({tag, ".done_after_last"}, done_k, last_hs + 1);
      if (pct >= 100) chk({tag, ".no_bubbles"}, last_hs - first_v + 1, got.size());
    end
    chk({tag, ".stack_empty"}, stk.size(), 0);
    @(negedge clk);
    chk({tag, ".done_one_cycle"}, done, 0);
    chk({tag, ".idle_busy"}, busy, 0);
    ready = 1'b0;
  endtask

  typedef struct packed {
    int                  n;
    int                  pct;
    bit                  mid;
    logic [7:0][DW-1:0]  d;
    int                  exp_words;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [7:0][DW-1:0] rd;
    logic [DW-1:0]      hs_data[$];
    int                 n, pct, hs;

    vecs[0] = '{8, 100, 1'b0, 64'h8877665544332211, 8};
    vecs[1] = '{8, 50,  1'b0, 64'h8877665544332211, 8};
    vecs[2] = '{0, 100, 1'b0, 64'h0, 0};
    vecs[3] = '{3, 100, 1'b1, 64'h0000000000C0B0A0, 3};
    vecs[4] = '{1, 40,  1'b0, 64'h000000000000005A, 1};
    vecs[5] = '{5, 25,  1'b1, 64'h0000000501020304, 5};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.valid", valid, 0);
    chk("rst.last", last, 0);
    chk("rst.rdreq", rdreq, 0);
    chk("rst.words", words, 0);
    chk("rst.data", data, 0);
    @(posedge clk); #1 srst = 1'b1;

    for (int v = 0; v < 6; v++) begin
      fill(vecs[v].n, vecs[v].d);
      drain(vecs[v].pct, vecs[v].mid, vecs[v].exp_words, $sformatf("vec%0d", v));
    end

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(8);
      pct = $urandom_range(20, 100);
      for (int i = 0; i < 8; i++) rd[i] = DW'($urandom);
      fill(n, rd);
      drain(pct, r[0], n, $sformatf("rnd%0d", r));
    end

    // Reset lands on the edge of the third handshake of a full-stack drain.
    fill(8, 64'h8877665544332211);
    @(posedge clk); #1 start = 1'b1; ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    hs = 0;
    for (int cyc = 1; cyc <= 20 && hs < 2; cyc++) begin
      @(negedge clk);
      if (valid && ready) begin
        hs_data.push_back(data);
        hs++;
      end
    end
    chk("rstmid.two_handshakes", hs, 2);
    if (hs_data.size() == 2) begin
      chk("rstmid.hs0", hs_data[0], 8'h88);
      chk("rstmid.hs1", hs_data[1], 8'h77);
    end
    @(posedge clk); #1 srst = 1'b0;
    @(negedge clk);
    chk("rstmid.hs2_valid", valid, 1);
    chk("rstmid.hs2_data", data, 8'h66);
    @(posedge clk); #1 srst = 1'b1; ready = 1'b0;
    @(negedge clk);
    chk("rstmid.busy", busy, 0);
    chk("rstmid.done", done, 0);
    chk("rstmid.valid", valid, 0);
    chk("rstmid.last", last, 0);
    chk("rstmid.rdreq", rdreq, 0);
    chk("rstmid.words", words, 0);
    chk("rstmid.data", data, 0);
    chk("rstmid.state_idle", dut.state, IDLE);
    chk("rstmid.pops_3_to_5", (stk.size() >= 3 && stk.size() <= 5), 1);
    drain(100, 1'b0, stk.size(), "rstmid.rem");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
